// File: rtl/sc_fifo_stream_rd.sv
// Read-side adapter for sc_fifo: issues reads ahead of demand and presents the
// returned words as a valid/ready stream through a 2-entry output buffer.
module sc_fifo_stream_rd #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [1:0]            buf_used_o
);

  // Stream handshake: a word transfers on a clock edge where valid_o and
  // ready_i are both 1. Once valid_o is raised, valid_o and data_o hold
  // until that transfer happens; valid_o never depends on ready_i.

  logic [1:0]            cnt_q, cnt_d;
  logic                  infl_q, infl_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  pop;
  logic [2:0]            occ_next;
  logic                  fifo_rd;

  always_comb begin
    pop      = 1'b0;
    occ_next = 3'd0;
    fifo_rd  = 1'b0;
    cnt_d    = cnt_q;
    infl_d   = infl_q;
    head_d   = head_q;
    tail_d   = tail_q;
    buf_d    = buf_q;
    data_d   = data_q;

    pop = (cnt_q != 2'd0) & ready_i;

    // Occupancy after this edge, counting the word already in flight, so a
    // new read is only issued when a buffer slot is guaranteed for it.
    occ_next = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    fifo_rd  = !rst_i && !fifo_empty_i && (occ_next < 3'd2);

    cnt_d  = occ_next[1:0];
    infl_d = fifo_rd;
    head_d = head_q ^ pop;
    tail_d = tail_q ^ infl_q;

    if (infl_q) begin
      buf_d[tail_q] = fifo_rd_data_i;
    end

    // The registered head follows the post-update buffer, so a word pushed
    // into an empty buffer is presented on the following clock.
    if (cnt_d != 2'd0) begin
      data_d = buf_d[head_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= 2'd0;
      infl_q   <= 1'b0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      data_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      data_q   <= data_d;
    end
  end

  assign fifo_rd_o  = fifo_rd;
  assign data_o     = data_q;
  assign valid_o    = (cnt_q != 2'd0);
  assign buf_used_o = cnt_q;

  a_no_rd_when_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_rd_o && fifo_empty_i));

  a_no_overcommit : assert property (@(posedge clk_i) disable iff (rst_i)
    (({1'b0, cnt_q} + {2'b0, infl_q}) <= 3'd2));

endmodule

// File: tb/tb_sc_fifo_stream_rd.sv
// Directed bench for sc_fifo_stream_rd with a behavioural 8-deep sc_fifo in
// front of it and an expected-word queue checking the stream side.
module tb_sc_fifo_stream_rd;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       fifo_rd_o;
  logic [7:0] fifo_rd_data_i = 8'h00;
  logic       fifo_empty_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [1:0] buf_used_o;

  // Behavioural FIFO: write port driven by the bench, 1-cycle read latency
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] mem [8];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;
  logic [3:0] f_cnt = 4'd0;

  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_err = 0;
  int         rd_pulses = 0;
  logic       last_valid = 1'b0;
  logic       last_ready = 1'b0;
  logic       last_rst = 1'b1;
  logic [7:0] last_data = 8'h00;
  logic [11:0] vld_hist;

  sc_fifo_stream_rd #(.DATA_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .fifo_rd_o      (fifo_rd_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .buf_used_o     (buf_used_o)
  );

  always #5 clk = ~clk;

  assign fifo_empty_i = (f_cnt == 4'd0);

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= wr_data;
      wp      <= wp + 3'd1;
    end
    if (fifo_rd_o) begin
      fifo_rd_data_i <= mem[rp];
      rp             <= rp + 3'd1;
    end
    f_cnt <= f_cnt + {3'b0, wr_en} - {3'b0, fifo_rd_o};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs at the falling edge: invariants, hold rule and scoreboard
  task automatic monitor();
    logic [7:0] exp_w;
    if (!rst_i) begin
      if (fifo_rd_o) rd_pulses++;
      check("no_rd_when_empty", {31'd0, fifo_rd_o & fifo_empty_i}, 32'd0);
      check("used_le_2", {31'd0, buf_used_o <= 2'd2}, 32'd1);
      check("valid_vs_used", {31'd0, valid_o}, {31'd0, buf_used_o != 2'd0});
      if (!last_rst && last_valid && !last_ready) begin
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_data", {24'd0, data_o}, {24'd0, last_data});
      end
      if (valid_o && ready_i) begin
        check("sb_has_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("sb_data", {24'd0, data_o}, {24'd0, exp_w});
        end
      end
    end
    last_valid = valid_o;
    last_ready = ready_i;
    last_data  = data_o;
    last_rst   = rst_i;
  endtask

  // One clock: monitor at negedge, return #1 after the next posedge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !valid_o && f_cnt == 4'd0) break;
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    check("drain_valid_low", {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    // Test 1: reset and idle with an empty FIFO
    rst_i   = 1'b1;
    ready_i = 1'b1;
    tick();
    check("t1_rd_in_reset", {31'd0, fifo_rd_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    check("t1_data_reset", {24'd0, data_o}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_rd_idle", {31'd0, fifo_rd_o}, 32'd0);
      check("t1_valid_idle", {31'd0, valid_o}, 32'd0);
      check("t1_used_idle", {30'd0, buf_used_o}, 32'd0);
    end

    // Test 2: single word latency
    rd_pulses = 0;
    push_word(8'hA5);
    tick();
    wr_en = 1'b0;
    check("t2_rd_at_T", {31'd0, fifo_rd_o}, 32'd1);
    check("t2_valid_at_T", {31'd0, valid_o}, 32'd0);
    tick();
    check("t2_rd_at_T1", {31'd0, fifo_rd_o}, 32'd0);
    check("t2_valid_at_T1", {31'd0, valid_o}, 32'd0);
    tick();
    check("t2_valid_at_T2", {31'd0, valid_o}, 32'd1);
    check("t2_data_at_T2", {24'd0, data_o}, 32'h0000_00A5);
    tick();
    check("t2_valid_after", {31'd0, valid_o}, 32'd0);
    check("t2_rd_pulses", rd_pulses, 32'd1);
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // Test 3: eight back-to-back words stream with no gaps
    vld_hist = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) push_word(i[7:0]);
      else wr_en = 1'b0;
      tick();
      vld_hist[i] = valid_o;
    end
    wr_en = 1'b0;
    check("t3_valid_run", {20'd0, vld_hist}, 32'h0000_03FC);
    drain(10);

    // Test 4: backpressure caps the buffer at two words
    ready_i   = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) push_word(8'h10 + i[7:0]);
      else wr_en = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    check("t4_used", {30'd0, buf_used_o}, 32'd2);
    check("t4_valid", {31'd0, valid_o}, 32'd1);
    check("t4_data_head", {24'd0, data_o}, 32'h0000_0010);
    check("t4_rd_pulses", rd_pulses, 32'd2);
    check("t4_fifo_left", {28'd0, f_cnt}, 32'd2);
    ready_i = 1'b1;
    drain(30);

    // Test 5: reset while a word is in flight
    push_word(8'h77);
    tick();
    push_word(8'h78);
    check("t5_rd_issued", {31'd0, fifo_rd_o}, 32'd1);
    tick();
    wr_en = 1'b0;
    rst_i = 1'b1;
    #1;
    check("t5_fifo_nonempty", {31'd0, fifo_empty_i}, 32'd0);
    check("t5_rd_blocked_in_reset", {31'd0, fifo_rd_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    check("t5_valid_after_reset", {31'd0, valid_o}, 32'd0);
    check("t5_used_after_reset", {30'd0, buf_used_o}, 32'd0);
    void'(exp_q.pop_front());
    drain(20);

    // Test 6: random writes and random backpressure
    for (int i = 0; i < 3000; i++) begin
      if (f_cnt < 4'd8 && $urandom_range(1, 0) == 1) push_word(8'($urandom_range(255, 0)));
      else wr_en = 1'b0;
      ready_i = 1'($urandom_range(1, 0));
      tick();
    end
    wr_en   = 1'b0;
    ready_i = 1'b1;
    drain(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
